// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA timing generator at the head of the draw pipeline.
// It walks a pixel position (h, v) across one frame and decodes the blanking
// and sync signals for that position. It also produces line/frame strobes and
// a count of completed frames.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous, active-low reset (overrides en)
//   en          pixel enable; one pixel step per clk edge with en=1
//   hcount      current pixel column, 0..H_TOT-1
//   vcount      current line, 0..V_TOT-1
//   hsync       horizontal sync, at level HS_POL while active
//   hblnk       horizontal blanking (h >= H_ACTIVE)
//   vsync       vertical sync, at level VS_POL while active
//   vblnk       vertical blanking (v >= V_ACTIVE)
//   line_start  one-cycle strobe when the outputs first show h=0 after a wrap
//   frame_start one-cycle strobe when the outputs first show (0,0) after a
//               full-frame wrap
//   frame_cnt   completed-frame counter, modulo 2**FW
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CW       = 11,
  parameter int FW       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          hblnk,
  output logic          vsync,
  output logic          vblnk,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_cnt
);

  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  // The counters must be able to hold the last position of a line and frame;
  // a narrower CW would silently alias positions, so refuse to elaborate.
  if ((H_TOT - 1) >= (2 ** CW) || (V_TOT - 1) >= (2 ** CW)) begin : g_cw_too_small
    $error("vga_timing_gen: CW=%0d cannot hold H_TOT-1=%0d / V_TOT-1=%0d",
           CW, H_TOT - 1, V_TOT - 1);
  end

  logic          h_wrap;
  logic          f_wrap;
  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic          hs_log;
  logic          vs_log;

  // Next position and its decodes. Everything is derived from the position
  // the outputs will show after this edge, so all registered outputs line up
  // on the same (h, v) with no extra pipeline stage downstream.
  always_comb begin
    h_wrap = (hcount == CW'(H_TOT - 1));
    f_wrap = h_wrap && (vcount == CW'(V_TOT - 1));
    h_nxt  = h_wrap ? '0 : hcount + CW'(1);
    v_nxt  = vcount;
    if (h_wrap) begin
      v_nxt = (vcount == CW'(V_TOT - 1)) ? '0 : vcount + CW'(1);
    end
    hs_log = (h_nxt >= CW'(HS_START)) && (h_nxt < CW'(HS_END));
    vs_log = (v_nxt >= CW'(VS_START)) && (v_nxt < CW'(VS_END));
  end

  // Output register. With en low everything holds and the strobes drop, so
  // a divided pixel clock sees exactly one position per enabled edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcount      <= '0;
      vcount      <= '0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (en) begin
        hcount      <= h_nxt;
        vcount      <= v_nxt;
        hblnk       <= (h_nxt >= CW'(H_ACTIVE));
        vblnk       <= (v_nxt >= CW'(V_ACTIVE));
        hsync       <= HS_POL ? hs_log : ~hs_log;
        vsync       <= VS_POL ? vs_log : ~vs_log;
        line_start  <= h_wrap;
        frame_start <= f_wrap;
        if (f_wrap) begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Drives two instances from one shared stimulus stream: the default 800x600
// configuration (horizontal boundaries, reset values) and a tiny 7x5 frame
// with active-low syncs (vertical decodes, frame strobes, frame_cnt wrap).
module tb_vga_timing_gen;

  logic clk;
  logic rst_n;
  logic en;

  logic [10:0] d_hcount, d_vcount;
  logic        d_hsync, d_hblnk, d_vsync, d_vblnk, d_ls, d_fs;
  logic [7:0]  d_fcnt;

  logic [3:0]  s_hcount, s_vcount;
  logic        s_hsync, s_hblnk, s_vsync, s_vblnk, s_ls, s_fs;
  logic [1:0]  s_fcnt;

  int errors = 0;
  int checks = 0;

  // Bench-side position trackers (updated per edge from the stimulus only)
  int dh, dv, dfc;
  bit dls, dfs;
  int sh, sv, sfc;
  bit sls, sfs;

  int en_edges = 0;
  int s_last_fs, s_last_ls, d_last_ls;

  vga_timing_gen dut_def (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hcount(d_hcount), .vcount(d_vcount),
    .hsync(d_hsync), .hblnk(d_hblnk), .vsync(d_vsync), .vblnk(d_vblnk),
    .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fcnt)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(4), .FW(2)
  ) dut_small (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hcount(s_hcount), .vcount(s_vcount),
    .hsync(s_hsync), .hblnk(s_hblnk), .vsync(s_vsync), .vblnk(s_vblnk),
    .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advances the bench trackers by one clock edge with the given inputs
  task automatic modelStep(input bit rst, input bit e);
    if (rst) begin
      dh = 0; dv = 0; dfc = 0; dls = 0; dfs = 0;
      sh = 0; sv = 0; sfc = 0; sls = 0; sfs = 0;
    end else if (e) begin
      dls = (dh == 1055);
      dfs = dls && (dv == 627);
      dh  = dls ? 0 : dh + 1;
      if (dls) dv = (dv == 627) ? 0 : dv + 1;
      if (dfs) dfc = (dfc + 1) % 256;
      sls = (sh == 6);
      sfs = sls && (sv == 4);
      sh  = sls ? 0 : sh + 1;
      if (sls) sv = (sv == 4) ? 0 : sv + 1;
      if (sfs) sfc = (sfc + 1) % 4;
    end else begin
      dls = 0; dfs = 0; sls = 0; sfs = 0;
    end
  endtask

  // Compares both instances against the trackers and hand-set boundaries
  task automatic checkAll(input bit e);
    checkOutput("def_hcount", d_hcount, dh);
    checkOutput("def_vcount", d_vcount, dv);
    checkOutput("def_hblnk", d_hblnk, (dh >= 800));
    checkOutput("def_hsync", d_hsync, (dh >= 840 && dh <= 967));
    checkOutput("def_vblnk", d_vblnk, (dv >= 600));
    checkOutput("def_vsync", d_vsync, (dv >= 601 && dv <= 604));
    checkOutput("def_line_start", d_ls, dls);
    checkOutput("def_frame_start", d_fs, dfs);
    checkOutput("def_frame_cnt", d_fcnt, dfc);
    checkOutput("sm_hcount", s_hcount, sh);
    checkOutput("sm_vcount", s_vcount, sv);
    checkOutput("sm_hblnk", s_hblnk, (sh >= 4));
    checkOutput("sm_hsync", s_hsync, (sh != 5));
    checkOutput("sm_vblnk", s_vblnk, (sv >= 2));
    checkOutput("sm_vsync", s_vsync, (sv != 3));
    checkOutput("sm_line_start", s_ls, sls);
    checkOutput("sm_frame_start", s_fs, sfs);
    checkOutput("sm_frame_cnt", s_fcnt, sfc);
    if (!e) begin
      checkOutput("def_no_strobe_when_idle", d_ls | d_fs, 0);
      checkOutput("sm_no_strobe_when_idle", s_ls | s_fs, 0);
    end
    // Spacing of strobes in enabled edges, independent of the trackers
    if (s_ls) begin
      checkOutput("sm_line_gap", en_edges - s_last_ls, 7);
      s_last_ls = en_edges;
    end
    if (s_fs) begin
      checkOutput("sm_frame_gap", en_edges - s_last_fs, 35);
      checkOutput("sm_fs_with_ls", s_ls, 1);
      s_last_fs = en_edges;
    end
    if (d_ls) begin
      checkOutput("def_line_gap", en_edges - d_last_ls, 1056);
      d_last_ls = en_edges;
    end
  endtask

  // One clock edge with the given inputs, then sample 1 ns after the edge
  task automatic applyStimulus(input bit rst, input bit e);
    rst_n = ~rst;
    en    = e;
    @(posedge clk);
    modelStep(rst, e);
    if (rst) begin
      s_last_fs = en_edges;
      s_last_ls = en_edges;
      d_last_ls = en_edges;
    end else if (e) begin
      en_edges++;
    end
    #1;
    checkAll(e);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    dh = 0; dv = 0; dfc = 0; dls = 0; dfs = 0;
    sh = 0; sv = 0; sfc = 0; sls = 0; sfs = 0;
    s_last_fs = 0; s_last_ls = 0; d_last_ls = 0;
    $display("[TB] start");

    // Reset held for 3 cycles with en high
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("rst_def_hsync_idle", d_hsync, 0);
    checkOutput("rst_sm_hsync_idle", s_hsync, 1);
    checkOutput("rst_sm_vsync_idle", s_vsync, 1);
    checkOutput("rst_def_hcount", d_hcount, 0);

    // First enabled edge after release: h=1
    applyStimulus(1'b0, 1'b1);
    checkOutput("post_rst_hcount", d_hcount, 1);

    // Two full default lines plus a few pixels; small frame wraps many times
    for (int i = 0; i < 2 * 1056 + 8; i++) begin
      applyStimulus(1'b0, 1'b1);
      if (dh == 800) checkOutput("hblnk_rise_800", d_hblnk, 1);
      if (dh == 840) checkOutput("hsync_rise_840", d_hsync, 1);
      if (dh == 968) checkOutput("hsync_fall_968", d_hsync, 0);
    end
    checkOutput("def_vcount_after_2_lines", d_vcount, 2);

    // en toggled in a 1,0,0,1 pattern
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'b0, (i % 4 == 0) || (i % 4 == 3));
    end

    // Mid-frame reset, then run more than one small frame
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("midrst_sm_hcount", s_hcount, 0);
    checkOutput("midrst_sm_vcount", s_vcount, 0);
    checkOutput("midrst_sm_frame_cnt", s_fcnt, 0);
    checkOutput("midrst_def_frame_cnt", d_fcnt, 0);
    for (int i = 0; i < 34; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("midrst_sm_no_early_fs", s_fs, 0);
    end
    applyStimulus(1'b0, 1'b1);
    checkOutput("midrst_sm_first_fs", s_fs, 1);
    checkOutput("midrst_sm_frame_cnt_1", s_fcnt, 1);

    // Three more frames: frame_cnt goes 2,3 then wraps to 0
    for (int i = 0; i < 3 * 35; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("sm_frame_cnt_wrap", s_fcnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
